// File: rtl/led_breathe_pwm.sv
// Breathing-LED PWM driver: prescaler -> PWM counter -> ramp FSM sweeping duty 0->max->0.
// All outputs are registered; duty and phase change only on a PWM period wrap.
module led_breathe_pwm #(
   parameter int unsigned PWM_BITS     = 8,
   parameter int unsigned PRESCALE     = 46,
   parameter int unsigned STEP_DIV     = 4,
   parameter int unsigned HOLD_PERIODS = 64
) (
   input  logic                clk_12m,
   input  logic                rst_n,
   input  logic                en,
   output logic                led_out,
   output logic [PWM_BITS-1:0] duty,
   output logic [2:0]          phase,
   output logic                period_tick
);

   localparam int unsigned PRE_W = (PRESCALE == 0) ? 1 : $clog2(PRESCALE + 1);

   localparam logic [PRE_W-1:0]    PRE_TC     = PRE_W'(PRESCALE);
   localparam logic [PWM_BITS-1:0] DUTY_MAX   = '1;
   localparam logic [PWM_BITS-1:0] DUTY_ONE   = PWM_BITS'(1);
   localparam logic [PWM_BITS-1:0] DUTY_MAXM1 = DUTY_MAX - DUTY_ONE;
   localparam logic [7:0]          STEP_TC    = 8'(STEP_DIV - 1);
   localparam logic [15:0]         HOLD_TC    = 16'(HOLD_PERIODS - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      UP      = 3'd1,
      HOLD_HI = 3'd2,
      DOWN    = 3'd3,
      HOLD_LO = 3'd4
   } phase_e;

   phase_e              phase_q;
   logic [PRE_W-1:0]    pre_cnt_q;
   logic [PWM_BITS-1:0] pwm_cnt_q;
   logic [PWM_BITS-1:0] duty_q;
   logic [7:0]          step_cnt_q;
   logic [15:0]         hold_cnt_q;
   logic                led_q;
   logic                period_tick_q;

   logic tick;
   logic wrap;
   logic step_due;
   logic hold_due;

   assign tick     = (pre_cnt_q == PRE_TC);
   assign wrap     = tick && (pwm_cnt_q == DUTY_MAX);
   assign step_due = (step_cnt_q == STEP_TC);
   assign hold_due = (hold_cnt_q == HOLD_TC);

   // NOTE: every register here is state, so all assignments are non-blocking to avoid
   // order-dependent simulation races between the counters and the FSM.
   always_ff @(posedge clk_12m or negedge rst_n) begin
      if (!rst_n) begin
         phase_q       <= IDLE;
         pre_cnt_q     <= '0;
         pwm_cnt_q     <= '0;
         duty_q        <= '0;
         step_cnt_q    <= '0;
         hold_cnt_q    <= '0;
         led_q         <= 1'b0;
         period_tick_q <= 1'b0;
      end else if (!en || phase_q == IDLE) begin
         // Idle (or being forced idle) keeps every counter parked at zero so a
         // fresh enable always starts a clean period with duty 0.
         phase_q       <= en ? UP : IDLE;
         pre_cnt_q     <= '0;
         pwm_cnt_q     <= '0;
         duty_q        <= '0;
         step_cnt_q    <= '0;
         hold_cnt_q    <= '0;
         led_q         <= 1'b0;
         period_tick_q <= 1'b0;
      end else begin
         pre_cnt_q     <= tick ? '0 : pre_cnt_q + 1'b1;
         led_q         <= (pwm_cnt_q < duty_q);
         period_tick_q <= wrap;
         if (tick) begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
         end
         if (wrap) begin
            unique case (phase_q)
               UP: begin
                  if (step_due) begin
                     step_cnt_q <= '0;
                     duty_q     <= duty_q + DUTY_ONE;
                     if (duty_q == DUTY_MAXM1) begin
                        phase_q    <= HOLD_HI;
                        hold_cnt_q <= '0;
                     end
                  end else begin
                     step_cnt_q <= step_cnt_q + 1'b1;
                  end
               end
               DOWN: begin
                  if (step_due) begin
                     step_cnt_q <= '0;
                     duty_q     <= duty_q - DUTY_ONE;
                     if (duty_q == DUTY_ONE) begin
                        phase_q    <= HOLD_LO;
                        hold_cnt_q <= '0;
                     end
                  end else begin
                     step_cnt_q <= step_cnt_q + 1'b1;
                  end
               end
               // Leaving a plateau counts as the first step of the next ramp, so the
               // bound value is not repeated for an extra period.
               HOLD_HI: begin
                  if (hold_due) begin
                     hold_cnt_q <= '0;
                     step_cnt_q <= '0;
                     duty_q     <= duty_q - DUTY_ONE;
                     phase_q    <= (duty_q == DUTY_ONE) ? HOLD_LO : DOWN;
                  end else begin
                     hold_cnt_q <= hold_cnt_q + 1'b1;
                  end
               end
               HOLD_LO: begin
                  if (hold_due) begin
                     hold_cnt_q <= '0;
                     step_cnt_q <= '0;
                     duty_q     <= duty_q + DUTY_ONE;
                     phase_q    <= (duty_q == DUTY_MAXM1) ? HOLD_HI : UP;
                  end else begin
                     hold_cnt_q <= hold_cnt_q + 1'b1;
                  end
               end
               default: phase_q <= IDLE;
            endcase
         end
      end
   end

   assign led_out     = led_q;
   assign duty        = duty_q;
   assign phase       = phase_q;
   assign period_tick = period_tick_q;

endmodule

// File: tb/tb_led_breathe_pwm.sv
// Self-checking bench for led_breathe_pwm: a period-schedule model (cycle count since enable)
// is compared against the DUT every cycle, plus literal spot checks and randomized en/reset.
`timescale 1ns/100ps
module tb_led_breathe_pwm;

   localparam int PERIOD = 16;

   logic       clk_12m = 1'b0;
   logic       rst_n;
   logic       en;
   logic       led_out;
   logic [2:0] duty;
   logic [2:0] phase;
   logic       period_tick;

   int checks   = 0;
   int failures = 0;

   bit m_active;
   int m_c;

   led_breathe_pwm #(
      .PWM_BITS    (3),
      .PRESCALE    (1),
      .STEP_DIV    (1),
      .HOLD_PERIODS(2)
   ) dut (
      .clk_12m    (clk_12m),
      .rst_n      (rst_n),
      .en         (en),
      .led_out    (led_out),
      .duty       (duty),
      .phase      (phase),
      .period_tick(period_tick)
   );

   always #5 clk_12m = ~clk_12m;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Phase and duty of the k-th PWM period after enable: ramp 0..6, plateau 7 x2,
   // then a repeating 16-period loop: down 6..1, low 0 x2, up 1..6, high 7 x2.
   function automatic void sched(input int k, output int ph, output int d);
      int j;
      if (k < 7) begin
         ph = 1; d = k;
      end else if (k < 9) begin
         ph = 2; d = 7;
      end else begin
         j = (k - 9) % 16;
         if (j < 6) begin
            ph = 3; d = 6 - j;
         end else if (j < 8) begin
            ph = 4; d = 0;
         end else if (j < 14) begin
            ph = 1; d = j - 7;
         end else begin
            ph = 2; d = 7;
         end
      end
   endfunction

   // Model state: m_c = clocks since the first enabled (UP) cycle.
   always @(posedge clk_12m or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 1'b0;
         m_c      <= 0;
      end else if (!en) begin
         m_active <= 1'b0;
         m_c      <= 0;
      end else if (!m_active) begin
         m_active <= 1'b1;
         m_c      <= 0;
      end else begin
         m_c <= m_c + 1;
      end
   end

   always @(negedge clk_12m) begin
      int e_ph, e_d, e_led, e_tick, o;
      e_ph = 0; e_d = 0; e_led = 0; e_tick = 0;
      if (m_active) begin
         o = m_c % PERIOD;
         sched(m_c / PERIOD, e_ph, e_d);
         e_led  = (o >= 1 && o <= 2 * e_d) ? 1 : 0;
         e_tick = (m_c > 0 && o == 0) ? 1 : 0;
      end
      check("model_led_out", int'(led_out), e_led);
      check("model_duty", int'(duty), e_d);
      check("model_phase", int'(phase), e_ph);
      check("model_period_tick", int'(period_tick), e_tick);
   end

   task automatic wait_c(input int target);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 5000 && !found; i++) begin
         @(negedge clk_12m);
         if (m_active && m_c == target) found = 1'b1;
      end
      check("wait_timeout", int'(found), 1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_led_out"}, int'(led_out), 0);
      check({tag, "_duty"}, int'(duty), 0);
      check({tag, "_phase"}, int'(phase), 0);
      check({tag, "_period_tick"}, int'(period_tick), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b1;
      repeat (5) @(negedge clk_12m);
      check_all_zero("reset");
      rst_n = 1'b1;

      // Ramp, plateaus and return to UP, pinned with literal values.
      wait_c(0);
      check("ramp_start_phase", int'(phase), 1);
      check("ramp_start_duty", int'(duty), 0);
      wait_c(PERIOD * 3 + 6);
      check("ramp_d3_led", int'(led_out), 1);
      check("ramp_d3_duty", int'(duty), 3);
      wait_c(PERIOD * 3 + 7);
      check("ramp_d3_led_off", int'(led_out), 0);
      wait_c(PERIOD * 7 + 4);
      check("hold_hi_phase", int'(phase), 2);
      check("hold_hi_duty", int'(duty), 7);
      wait_c(PERIOD * 8 + 15);
      check("hold_hi_tail_low", int'(led_out), 0);
      wait_c(PERIOD * 9);
      check("down_phase", int'(phase), 3);
      check("down_duty", int'(duty), 6);
      check("down_tick", int'(period_tick), 1);
      wait_c(PERIOD * 15 + 5);
      check("hold_lo_phase", int'(phase), 4);
      check("hold_lo_led", int'(led_out), 0);
      wait_c(PERIOD * 17);
      check("reup_phase", int'(phase), 1);
      check("reup_duty", int'(duty), 1);

      // Disable mid-period while high in UP at duty 5.
      wait_c(PERIOD * 21 + 3);
      check("dis_pre_led", int'(led_out), 1);
      check("dis_pre_duty", int'(duty), 5);
      check("dis_pre_phase", int'(phase), 1);
      en = 1'b0;
      @(negedge clk_12m);
      check_all_zero("disable");
      @(negedge clk_12m);
      en = 1'b1;
      wait_c(0);
      check("reen_duty", int'(duty), 0);
      wait_c(PERIOD);
      check("reen_duty1", int'(duty), 1);

      // Async reset pulse mid-DOWN, then the ramp must repeat from scratch.
      wait_c(PERIOD * 10 + 5);
      check("mid_down_phase", int'(phase), 3);
      check("mid_down_duty", int'(duty), 5);
      @(posedge clk_12m);
      #2 rst_n = 1'b0;
      #0.5 check_all_zero("async_reset");
      #0.5 rst_n = 1'b1;
      wait_c(PERIOD * 3 + 2);
      check("post_rst_duty", int'(duty), 3);
      check("post_rst_led", int'(led_out), 1);

      // Randomized en toggling and occasional async reset pulses.
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk_12m);
         if (en && $urandom_range(0, 399) == 0) en = 1'b0;
         else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
         if ($urandom_range(0, 999) == 0) begin
            #2 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
      end

      @(negedge clk_12m);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
